// File: rtl/l2_arbiter.sv
// Two-client miss arbiter: funnels L1 I-cache fills and L1 D-cache fills/writebacks
// onto one L2 port, one transaction at a time, with alternating priority on ties.
module l2_arbiter #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_D,
        S_BUSY_I,
        S_RESP_D,
        S_RESP_I
    } state_t;

    state_t                r_state;
    logic                  r_last_d;
    logic                  r_l2_read;
    logic                  r_l2_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;

    logic w_d_req;
    logic w_grant_d;

    // D wins when I is idle or when I had the previous grant.
    assign w_d_req   = d_read | d_write;
    assign w_grant_d = w_d_req & (~i_read | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b0;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_i_resp   <= 1'b0;
            r_d_resp   <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= S_BUSY_D;
                        r_last_d   <= 1'b1;
                        r_l2_write <= d_write;
                        r_l2_read  <= ~d_write;
                        r_addr     <= d_address & LINE_MASK;
                        r_wdata    <= d_wdata;
                    end else if (i_read) begin
                        r_state    <= S_BUSY_I;
                        r_last_d   <= 1'b0;
                        r_l2_write <= 1'b0;
                        r_l2_read  <= 1'b1;
                        r_addr     <= i_address & LINE_MASK;
                    end
                end
                S_BUSY_D: begin
                    if (l2_resp) begin
                        if (!r_l2_write) begin
                            r_d_rdata <= l2_rdata;
                        end
                        r_l2_read  <= 1'b0;
                        r_l2_write <= 1'b0;
                        r_d_resp   <= 1'b1;
                        r_state    <= S_RESP_D;
                    end
                end
                S_BUSY_I: begin
                    if (l2_resp) begin
                        r_i_rdata <= l2_rdata;
                        r_l2_read <= 1'b0;
                        r_i_resp  <= 1'b1;
                        r_state   <= S_RESP_I;
                    end
                end
                S_RESP_D, S_RESP_I: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign i_resp     = r_i_resp;
    assign d_resp     = r_d_resp;
    assign l2_read    = r_l2_read;
    assign l2_write   = r_l2_write;
    assign l2_address = r_addr;
    assign l2_wdata   = r_wdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_read && d_write))
        else $error("l2_arbiter: d_read and d_write asserted together");

    a_stray_l2_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != S_BUSY_D && r_state != S_BUSY_I) |-> !l2_resp)
        else $warning("l2_arbiter: l2_resp outside a transaction ignored");

    a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_i_resp && r_d_resp))
        else $error("l2_arbiter: i_resp and d_resp both high");

    a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_l2_read && r_l2_write))
        else $error("l2_arbiter: l2_read and l2_write both high");

endmodule
